lock_ctrl: RTL
==============

LOCK_CTRL -- requirements
Module: lock_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the number of digits per code.
REQ-002 Parameter DEFAULT_CODE, default 16'h1234, SHALL set the code loaded at reset (4 bits per digit, first digit in MSBs).
REQ-003 Parameter MAX_TRIES, default 3, SHALL set the consecutive wrong entries that trigger lockout.
REQ-004 Parameter LOCKOUT_CYC, default 16, SHALL set the lockout duration in clk cycles.
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 key_valid  in  1  one-cycle strobe qualifying key_digit.
REQ-008 key_digit  in  4  entered digit, sampled only when key_valid=1.
REQ-009 key_clear  in  1  discard the partial entry.
REQ-010 lock_cmd  in  1  relock request, honoured in UNLOCKED and PROGRAM.
REQ-011 prog_req  in  1  enter code-programming mode (PROG feature only).
REQ-012 unlocked  out  1  high while in UNLOCKED or PROGRAM.
REQ-013 alarm  out  1  high while in LOCKOUT.
REQ-014 fail_cnt  out  2  consecutive wrong entries.
REQ-015 digit_cnt  out  3  digits captured in the current entry.

Function
REQ-016 The FSM SHALL have states LOCKED, CHECK, UNLOCKED, PROGRAM, LOCKOUT; all outputs registered.
REQ-017 In LOCKED, key_valid SHALL shift key_digit into the entry buffer and increment digit_cnt.
REQ-018 On capture of digit DIGITS, the FSM SHALL enter CHECK on that edge and clear digit_cnt.
REQ-019 key_clear SHALL clear the buffer and digit_cnt, with priority over a same-cycle key_valid.
REQ-020 CHECK SHALL last exactly one cycle; key_valid SHALL be ignored in CHECK and LOCKOUT.
REQ-021 On a match, CHECK SHALL go to UNLOCKED and clear fail_cnt; unlocked SHALL rise on the second edge after the final digit is sampled.
REQ-022 On a mismatch, fail_cnt SHALL increment; if it reaches MAX_TRIES the FSM SHALL go to LOCKOUT, otherwise to LOCKED.
REQ-023 LOCKOUT SHALL last exactly LOCKOUT_CYC cycles, then return to LOCKED with fail_cnt=0.
REQ-024 fail_cnt SHALL saturate at MAX_TRIES and never wrap.
REQ-025 In UNLOCKED, lock_cmd SHALL return to LOCKED on the next edge with the buffer cleared.
REQ-026 If lock_cmd and prog_req are both high in UNLOCKED, lock_cmd SHALL win.

Reset
REQ-027 When rst=0 at an edge: state=LOCKED, unlocked=0, alarm=0, fail_cnt=0, digit_cnt=0, buffer=0, code register=DEFAULT_CODE.
REQ-028 Reset SHALL abort any state, including a mid-entry, PROGRAM or LOCKOUT state, on the same edge.

Configuration
REQ-029 With LOCK_CTRL_PROG_EN defined, prog_req in UNLOCKED SHALL enter PROGRAM. DIGITS key_valid digits SHALL then overwrite the code register, and the FSM SHALL return to UNLOCKED. key_clear or lock_cmd in PROGRAM SHALL abort and retain the old code (lock_cmd goes to LOCKED, key_clear to UNLOCKED).
REQ-030 Without LOCK_CTRL_PROG_EN, prog_req SHALL be ignored, PROGRAM SHALL be unreachable, and the code SHALL be the constant DEFAULT_CODE.

Structure
REQ-031 The shared package lock_pkg SHALL hold the state encoding, the digit width (4) and the shared timing constants.
REQ-032 The lockout counter SHALL be the sub-module lock_timer (start, done), instantiated once.

Verification
REQ-033 Reset, then digits 1,2,3,4 -> unlocked=1 two edges after digit 4; fail_cnt=0.
REQ-034 Enter 1,2,3,5 three times -> fail_cnt counts 1, 2, 3. On the third, alarm=1 for exactly 16 cycles, digits are ignored, then alarm=0 and fail_cnt=0.
REQ-035 Enter 1,2, pulse key_clear with a same-cycle key_valid, then 1,2,3,4 -> digit_cnt=0 after the clear, and unlock succeeds.
REQ-036 While unlocked, lock_cmd=1 -> unlocked=0 next edge. Drive rst=0 mid-entry after 2 digits -> digit_cnt=0, and a full code is needed afterwards.
REQ-037 With PROG_EN: unlock, prog_req, enter 9,8,7,6, lock_cmd -> 1,2,3,4 fails and 9,8,7,6 unlocks. Abort PROGRAM after 2 digits -> old code still valid.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock controller: state encoding, digit width,
// default sizing and the lockout timer lead used to align the alarm window.
package lock_pkg;

    localparam int unsigned DIGIT_W         = 4;
    localparam int unsigned DEF_DIGITS      = 4;
    localparam int unsigned DEF_MAX_TRIES   = 3;
    localparam int unsigned DEF_LOCKOUT_CYC = 16;
    localparam int unsigned FAIL_W          = 2;
    localparam int unsigned DCNT_W          = 3;

    // done is registered and the FSM acts on it one edge later, so the timer fires this early
    localparam int unsigned TIMER_LEAD      = 2;

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_PROGRAM  = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_e;

    function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v,
                                                  input logic [FAIL_W-1:0] lim);
        return (v >= lim) ? lim : FAIL_W'(v + FAIL_W'(1));
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Lockout duration timer: a start pulse arms it and done pulses so that the
// controller leaves LOCKOUT exactly CYCLES edges after the start edge (CYCLES >= 2).
module lock_timer
    import lock_pkg::*;
#(
    parameter int unsigned CYCLES = DEF_LOCKOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int unsigned    CNT_W = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - TIMER_LEAD);

    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_cnt <= '0;
                r_run <= 1'b1;
            end else if (r_run) begin
                if (r_cnt == LAST) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
                r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
            end
        end
    end

    assign done = r_done;

endmodule

// File: rtl/lock_ctrl.sv
// Keypad lock controller: digit entry, code check, retry lockout and relock.
// Define LOCK_CTRL_PROG_EN to allow reprogramming the code while unlocked.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned                   DIGITS       = DEF_DIGITS,
    parameter logic [DIGITS*DIGIT_W-1:0]     DEFAULT_CODE = 16'h1234,
    parameter int unsigned                   MAX_TRIES    = DEF_MAX_TRIES,
    parameter int unsigned                   LOCKOUT_CYC  = DEF_LOCKOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               key_clear,
    input  logic               lock_cmd,
    input  logic               prog_req,
    output logic               unlocked,
    output logic               alarm,
    output logic [FAIL_W-1:0]  fail_cnt,
    output logic [DCNT_W-1:0]  digit_cnt
);

    localparam int unsigned       CODE_W     = DIGITS * DIGIT_W;
    localparam logic [DCNT_W-1:0] LAST_DIGIT = DCNT_W'(DIGITS - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX   = FAIL_W'(MAX_TRIES);

    state_e              r_state;
    logic [CODE_W-1:0]   r_buf;
    logic [DCNT_W-1:0]   r_dcnt;
    logic [FAIL_W-1:0]   r_fail;
    logic                r_unlocked;
    logic                r_alarm;

    logic [CODE_W-1:0]   w_code;
    logic [CODE_W-1:0]   w_shifted;
    logic [FAIL_W-1:0]   w_fail_next;
    logic                w_match;
    logic                w_timer_start;
    logic                w_timer_done;

`ifdef LOCK_CTRL_PROG_EN
    logic [CODE_W-1:0]   r_code;
    assign w_code = r_code;
`else
    logic                w_unused_prog;
    assign w_code        = DEFAULT_CODE;
    assign w_unused_prog = prog_req;
`endif

    // New digit enters at the LSBs so the first digit ends up in the MSBs
    assign w_shifted     = CODE_W'({r_buf, key_digit});
    assign w_fail_next   = sat_inc(r_fail, FAIL_MAX);
    assign w_match       = (r_buf == w_code);
    assign w_timer_start = (r_state == ST_CHECK) && !w_match && (w_fail_next == FAIL_MAX);

    lock_timer #(
        .CYCLES (LOCKOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (w_timer_start),
        .done  (w_timer_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_LOCKED;
            r_buf      <= '0;
            r_dcnt     <= '0;
            r_fail     <= '0;
            r_unlocked <= 1'b0;
            r_alarm    <= 1'b0;
`ifdef LOCK_CTRL_PROG_EN
            r_code     <= DEFAULT_CODE;
`endif
        end else begin
            case (r_state)
                ST_LOCKED: begin
                    if (key_clear) begin
                        r_buf  <= '0;
                        r_dcnt <= '0;
                    end else if (key_valid) begin
                        r_buf <= w_shifted;
                        if (r_dcnt == LAST_DIGIT) begin
                            r_dcnt  <= '0;
                            r_state <= ST_CHECK;
                        end else begin
                            r_dcnt <= DCNT_W'(r_dcnt + DCNT_W'(1));
                        end
                    end
                end

                ST_CHECK: begin
                    r_buf <= '0;
                    if (w_match) begin
                        r_state    <= ST_UNLOCKED;
                        r_unlocked <= 1'b1;
                        r_fail     <= '0;
                    end else begin
                        r_fail <= w_fail_next;
                        if (w_fail_next == FAIL_MAX) begin
                            r_state <= ST_LOCKOUT;
                            r_alarm <= 1'b1;
                        end else begin
                            r_state <= ST_LOCKED;
                        end
                    end
                end

                ST_UNLOCKED: begin
                    if (lock_cmd) begin
                        r_state    <= ST_LOCKED;
                        r_unlocked <= 1'b0;
                        r_buf      <= '0;
                        r_dcnt     <= '0;
                    end
`ifdef LOCK_CTRL_PROG_EN
                    else if (prog_req) begin
                        r_state <= ST_PROGRAM;
                        r_buf   <= '0;
                        r_dcnt  <= '0;
                    end
`endif
                end

                ST_PROGRAM: begin
`ifdef LOCK_CTRL_PROG_EN
                    // Abort paths leave r_code untouched
                    if (lock_cmd) begin
                        r_state    <= ST_LOCKED;
                        r_unlocked <= 1'b0;
                        r_buf      <= '0;
                        r_dcnt     <= '0;
                    end else if (key_clear) begin
                        r_state <= ST_UNLOCKED;
                        r_buf   <= '0;
                        r_dcnt  <= '0;
                    end else if (key_valid) begin
                        if (r_dcnt == LAST_DIGIT) begin
                            r_code  <= w_shifted;
                            r_buf   <= '0;
                            r_dcnt  <= '0;
                            r_state <= ST_UNLOCKED;
                        end else begin
                            r_buf  <= w_shifted;
                            r_dcnt <= DCNT_W'(r_dcnt + DCNT_W'(1));
                        end
                    end
`else
                    r_state    <= ST_LOCKED;
                    r_unlocked <= 1'b0;
                    r_buf      <= '0;
                    r_dcnt     <= '0;
`endif
                end

                ST_LOCKOUT: begin
                    if (w_timer_done) begin
                        r_state <= ST_LOCKED;
                        r_alarm <= 1'b0;
                        r_fail  <= '0;
                    end
                end

                default: begin
                    r_state    <= ST_LOCKED;
                    r_unlocked <= 1'b0;
                    r_alarm    <= 1'b0;
                    r_buf      <= '0;
                    r_dcnt     <= '0;
                end
            endcase
        end
    end

    assign unlocked  = r_unlocked;
    assign alarm     = r_alarm;
    assign fail_cnt  = r_fail;
    assign digit_cnt = r_dcnt;

endmodule
